// File: rtl/piano_voice_engine_if.sv
// piano_voice_engine_if: the key, mode, table, song and output bundle of the
// piano voice engine. The master side drives keys and programming writes.
// The slave side is the engine itself.
interface piano_voice_engine_if #(
   parameter int NUM_KEYS = 8,
   parameter int DIV_W    = 18,
   parameter int SONG_LEN = 32
);
   localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;

   logic [NUM_KEYS-1:0] keys_i;
   logic [1:0]          mode_i;
   logic                start_i;
   logic                tbl_we_i;
   logic [KW-1:0]       tbl_idx_i;
   logic [DIV_W-1:0]    tbl_data_i;
   logic                song_we_i;
   logic [AW-1:0]       song_addr_i;
   logic [KW+3:0]       song_wdata_i;

   logic                freq_o;
   logic                note_valid_o;
   logic [KW-1:0]       note_o;
   logic [NUM_KEYS-1:0] led_o;
   logic                busy_o;
   logic                done_o;
   logic [7:0]          miss_cnt_o;

   modport master (
      output keys_i, mode_i, start_i, tbl_we_i, tbl_idx_i, tbl_data_i,
             song_we_i, song_addr_i, song_wdata_i,
      input  freq_o, note_valid_o, note_o, led_o, busy_o, done_o, miss_cnt_o
   );

   modport slave (
      input  keys_i, mode_i, start_i, tbl_we_i, tbl_idx_i, tbl_data_i,
             song_we_i, song_addr_i, song_wdata_i,
      output freq_o, note_valid_o, note_o, led_o, busy_o, done_o, miss_cnt_o
   );
endinterface

// File: rtl/piano_voice_engine.sv
// piano_voice_engine: N-key tone generator with a programmable pitch table.
// A song memory feeds a single sequencer FSM.
// The FSM covers free play, lesson (wait for the correct key) and autoplay.
// Optional macro PIANO_ARTIC_EN inserts a one-beat silent GAP after every
// autoplay note.
module piano_voice_engine #(
   parameter int NUM_KEYS = 8,
   parameter int DIV_W    = 18,
   parameter int SONG_LEN = 32,
   parameter int BEAT_DIV = 12500000
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   piano_voice_engine_if.slave  bus
);
   localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
   localparam int AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
   localparam int BW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
`ifdef PIANO_ARTIC_EN
   localparam bit ARTIC = 1'b1;
`else
   localparam bit ARTIC = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_PLAY, S_GAP, S_WAIT_KEY, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q;
   logic [1:0]        run_mode_q;
   logic [KW-1:0]     play_key_q;
   logic [3:0]        dur_q;
   logic [BW-1:0]     beat_q;
   logic [7:0]        miss_q;
   logic              prev_valid_q;
   logic [KW-1:0]     prev_key_q;
   logic [KW+3:0]     rd_q;
   logic [KW+3:0]     song_mem [SONG_LEN];
   logic [DIV_W-1:0]  tbl_q [NUM_KEYS];

   logic              note_valid_q;
   logic [KW-1:0]     note_q;
   logic [DIV_W-1:0]  per_q;
   logic [DIV_W-1:0]  cnt_q;
   logic              freq_q;

   logic              sel_valid;
   logic [KW-1:0]     sel_key;
   logic [3:0]        rd_dur;
   logic [KW-1:0]     rd_key;
   logic              start_ok, abort, beat_tc, play_end, last_addr;
   logic              hit, miss_press, adv;
   logic              src_valid;
   logic [KW-1:0]     src_key;
   logic              chg;
   logic              busy, done;
   logic [NUM_KEYS-1:0] led;

   assign rd_dur = rd_q[KW+3:KW];
   assign rd_key = rd_q[KW-1:0];

   // Lowest-index asserted key wins
   always_comb begin
      sel_valid = 1'b0;
      sel_key   = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (bus.keys_i[i]) begin
            sel_valid = 1'b1;
            sel_key   = KW'(i);
         end
      end
   end

   // Sequencer control decode: start, abort, beat end and advance conditions
   always_comb begin
      start_ok   = bus.start_i && (bus.mode_i == 2'b01 || bus.mode_i == 2'b10);
      abort      = (state_q != S_IDLE) && (bus.mode_i != run_mode_q);
      beat_tc    = (beat_q == BW'(BEAT_DIV - 1));
      play_end   = (state_q == S_PLAY) && beat_tc && (dur_q == 4'd1);
      last_addr  = (addr_q == AW'(SONG_LEN - 1));
      // Rising selection of the expected key, or a fresh press of a wrong one
      hit        = sel_valid && (sel_key == play_key_q) &&
                   !(prev_valid_q && prev_key_q == play_key_q);
      miss_press = sel_valid && (sel_key != play_key_q) && !prev_valid_q;
      adv        = !abort && !start_ok &&
                   ((play_end && !ARTIC) ||
                    (state_q == S_GAP && beat_tc) ||
                    (state_q == S_WAIT_KEY && hit));
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: abort beats start, start beats normal sequencing
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else if (start_ok) begin
         state_d = S_FETCH;
      end else if (adv) begin
         state_d = last_addr ? S_DONE : S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
               if (rd_dur == 4'd0)          state_d = S_DONE;
               else if (run_mode_q == 2'b10) state_d = S_PLAY;
               else                          state_d = S_WAIT_KEY;
            end
            S_PLAY:   if (play_end) state_d = S_GAP;
            S_DONE:   state_d = S_IDLE;
            default:  ;
         endcase
      end
   end

   // FSM outputs: status flags and the one-hot guide LEDs
   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
      led  = '0;
      if (state_q == S_WAIT_KEY || state_q == S_PLAY)
         led = NUM_KEYS'(1) << play_key_q;
   end

   // Sequencer datapath: address, current entry, beat/duration timers, misses
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q       <= '0;
         run_mode_q   <= 2'b00;
         play_key_q   <= '0;
         dur_q        <= '0;
         beat_q       <= '0;
         miss_q       <= '0;
         prev_valid_q <= 1'b0;
         prev_key_q   <= '0;
      end else begin
         prev_valid_q <= sel_valid;
         prev_key_q   <= sel_key;
         if (start_ok && !abort) begin
            addr_q     <= '0;
            run_mode_q <= bus.mode_i;
         end else if (adv && !last_addr) begin
            addr_q <= addr_q + AW'(1);
         end
         if (state_q == S_DECODE) begin
            play_key_q <= rd_key;
            dur_q      <= rd_dur;
            beat_q     <= '0;
         end else if (state_q == S_PLAY || state_q == S_GAP) begin
            beat_q <= beat_tc ? '0 : beat_q + BW'(1);
            if (state_q == S_PLAY && beat_tc) dur_q <= dur_q - 4'd1;
         end else begin
            beat_q <= '0;
         end
         if (start_ok && !abort)
            miss_q <= '0;
         else if (state_q == S_WAIT_KEY && miss_press && !abort && !start_ok &&
                  miss_q != 8'hFF)
            miss_q <= miss_q + 8'd1;
      end
   end

   // Song memory: writable only while idle, registered read at addr
   always_ff @(posedge clk_i) begin
      if (bus.song_we_i && state_q == S_IDLE) song_mem[bus.song_addr_i] <= bus.song_wdata_i;
      rd_q <= song_mem[addr_q];
   end

   // Pitch table entries, each a resettable half-period register
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_tbl
      // Per-entry write port
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)                                           tbl_q[gi] <= '0;
         else if (bus.tbl_we_i && bus.tbl_idx_i == KW'(gi)) tbl_q[gi] <= bus.tbl_data_i;
      end
   end

   // Sound source: sequencer note in autoplay (valid from PLAY entry), keys otherwise
   always_comb begin
      if (bus.mode_i == 2'b10) begin
         src_valid = (state_d == S_PLAY);
         src_key   = (state_q == S_DECODE) ? rd_key : play_key_q;
      end else begin
         src_valid = sel_valid;
         src_key   = sel_key;
      end
      if (!src_valid) src_key = '0;
      chg = (src_valid != note_valid_q) || (src_key != note_q);
   end

   // Tone generator: latched half-period, reloaded at terminal count or note change
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         note_valid_q <= 1'b0;
         note_q       <= '0;
         per_q        <= '0;
         cnt_q        <= '0;
         freq_q       <= 1'b0;
      end else begin
         note_valid_q <= src_valid;
         note_q       <= src_key;
         if (chg) begin
            cnt_q  <= '0;
            freq_q <= 1'b0;
            per_q  <= src_valid ? tbl_q[src_key] : '0;
         end else if (!note_valid_q) begin
            cnt_q  <= '0;
            freq_q <= 1'b0;
         end else if (per_q == '0) begin
            // Silent entry: keep polling the table so a new pitch takes hold
            cnt_q  <= '0;
            freq_q <= 1'b0;
            per_q  <= tbl_q[note_q];
         end else if (cnt_q == per_q - DIV_W'(1)) begin
            cnt_q  <= '0;
            freq_q <= ~freq_q;
            per_q  <= tbl_q[note_q];
         end else begin
            cnt_q <= cnt_q + DIV_W'(1);
         end
      end
   end

   assign bus.freq_o       = freq_q;
   assign bus.note_valid_o = note_valid_q;
   assign bus.note_o       = note_q;
   assign bus.led_o        = led;
   assign bus.busy_o       = busy;
   assign bus.done_o       = done;
   assign bus.miss_cnt_o   = miss_q;
endmodule

// File: tb/tb_piano_voice_engine.sv
// tb_piano_voice_engine: priority vectors, hand-written tone/lesson/abort/reset
// sequences, random free play against a cycles-since-change tone model, and
// autoplay traces built from the song contents.
module tb_piano_voice_engine;
   localparam int NK = 8;
   localparam int DW = 18;
   localparam int SL = 32;
   localparam int BD = 4;
`ifdef PIANO_ARTIC_EN
   localparam int ARTIC = 1;
`else
   localparam int ARTIC = 0;
`endif

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       valid;
      logic [2:0] note;
      logic [7:0] led;
   } obs_t;

   typedef struct {
      logic [7:0] keys;
      logic       exp_valid;
      int         exp_note;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   piano_voice_engine_if #(.NUM_KEYS(NK), .DIV_W(DW), .SONG_LEN(SL)) bus ();

   piano_voice_engine #(.NUM_KEYS(NK), .DIV_W(DW), .SONG_LEN(SL), .BEAT_DIV(BD)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int         cmp_cnt = 0;
   int         err_cnt = 0;
   logic [6:0] song_tb [SL];
   int         tbl_tb  [NK];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int prio(input logic [7:0] k);
      for (int i = 0; i < 8; i++) if (k[i]) return i;
      return -1;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.busy  = bus.busy_o;
      o.done  = bus.done_o;
      o.valid = bus.note_valid_o;
      o.note  = bus.note_valid_o ? bus.note_o : 3'd0;
      o.led   = bus.led_o;
      return o;
   endfunction

   task automatic tbl_write(input int idx, input int val);
      bus.tbl_we_i   = 1'b1;
      bus.tbl_idx_i  = 3'(idx);
      bus.tbl_data_i = 18'(val);
      @(negedge clk);
      bus.tbl_we_i   = 1'b0;
      tbl_tb[idx]    = val;
   endtask

   task automatic song_write(input int addr, input int dur, input int key);
      bus.song_we_i    = 1'b1;
      bus.song_addr_i  = 5'(addr);
      bus.song_wdata_i = {4'(dur), 3'(key)};
      @(negedge clk);
      bus.song_we_i    = 1'b0;
      song_tb[addr]    = {4'(dur), 3'(key)};
   endtask

   // Autoplay: expected per-cycle trace derived from the song entries
   task automatic auto_check(input string tag, input bit inject);
      obs_t q[$];
      obs_t s, d, p;
      int   dur;
      int   e0 = err_cnt;
      s = '0; s.busy = 1'b1;
      d = s;  d.done = 1'b1;
      for (int i = 0; i < SL; i++) begin
         q.push_back(s);                   // FETCH
         q.push_back(s);                   // DECODE
         dur = int'(song_tb[i][6:3]);
         if (dur == 0) begin
            q.push_back(d);
            break;
         end
         p = s; p.valid = 1'b1; p.note = song_tb[i][2:0];
         p.led = 8'(1) << song_tb[i][2:0];
         repeat (dur * BD) q.push_back(p);
         if (ARTIC != 0) repeat (BD) q.push_back(s);
         if (i == SL - 1) q.push_back(d);
      end
      q.push_back('0);
      bus.mode_i  = 2'b10;
      bus.start_i = 1'b1;
      foreach (q[k]) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         if (inject) begin
            bus.song_we_i    = (k == 4);
            bus.song_addr_i  = 5'd1;
            bus.song_wdata_i = 7'h0F;
         end
         check($sformatf("%s[%0d]", tag, k), 32'(observe()), 32'(q[k]));
      end
      bus.song_we_i = 1'b0;
      $display("autoplay %s: %0d cycles, %0d errors", tag, q.size(), err_cnt - e0);
   endtask

   // Free play: random keys vs. model of note select and cycles since last change
   task automatic rand_free(input int ncyc);
      int m = 0, hold = 0, n_exp = 0, pn, t;
      bit v_exp = 0, pv, f_exp;
      int e0 = err_cnt;
      bus.mode_i = 2'b00;
      bus.keys_i = '0;
      repeat (3) @(negedge clk);
      for (int c = 0; c < ncyc; c++) begin
         if (hold == 0) begin
            bus.keys_i = ($urandom_range(0, 4) == 0) ? 8'h00 :
                         8'($urandom_range(0, 255) & $urandom_range(0, 255));
            hold = $urandom_range(1, 25);
         end
         hold--;
         @(posedge clk);
         pv = v_exp; pn = n_exp;
         v_exp = (bus.keys_i != 8'h00);
         n_exp = v_exp ? prio(bus.keys_i) : 0;
         if (v_exp != pv || (v_exp && n_exp != pn)) m = 0;
         else m++;
         t = tbl_tb[n_exp];
         f_exp = (v_exp && t != 0) ? (((m / t) % 2) == 1) : 1'b0;
         @(negedge clk);
         check($sformatf("rnd_valid[%0d]", c), 32'(bus.note_valid_o), 32'(v_exp));
         if (v_exp) check($sformatf("rnd_note[%0d]", c), 32'(bus.note_o), 32'(n_exp));
         check($sformatf("rnd_freq[%0d]", c), 32'(bus.freq_o), 32'(f_exp));
      end
      bus.keys_i = '0;
      @(negedge clk);
      $display("random free play: %0d cycles, %0d errors", ncyc, err_cnt - e0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   seen, pulses, mexp;

      vecs[0] = '{8'h00, 1'b0, 0};
      vecs[1] = '{8'h01, 1'b1, 0};
      vecs[2] = '{8'h80, 1'b1, 7};
      vecs[3] = '{8'h06, 1'b1, 1};
      vecs[4] = '{8'hF0, 1'b1, 4};
      vecs[5] = '{8'hFF, 1'b1, 0};
      vecs[6] = '{8'h48, 1'b1, 3};
      vecs[7] = '{8'h20, 1'b1, 5};

      bus.keys_i = '0; bus.mode_i = 2'b00; bus.start_i = 1'b0;
      bus.tbl_we_i = 1'b0; bus.tbl_idx_i = '0; bus.tbl_data_i = '0;
      bus.song_we_i = 1'b0; bus.song_addr_i = '0; bus.song_wdata_i = '0;
      for (int i = 0; i < NK; i++) tbl_tb[i] = 0;

      // Reset values
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_freq",  32'(bus.freq_o),       32'd0);
      check("rst_valid", 32'(bus.note_valid_o), 32'd0);
      check("rst_note",  32'(bus.note_o),       32'd0);
      check("rst_led",   32'(bus.led_o),        32'd0);
      check("rst_busy",  32'(bus.busy_o),       32'd0);
      check("rst_done",  32'(bus.done_o),       32'd0);
      check("rst_miss",  32'(bus.miss_cnt_o),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: outputs checked");

      // Key priority vectors
      for (int i = 0; i < 8; i++) begin
         bus.keys_i = vecs[i].keys;
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), 32'(bus.note_valid_o), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d_note", i), 32'(bus.note_o), 32'(vecs[i].exp_note));
         check($sformatf("vec%0d_led", i), 32'(bus.led_o), 32'd0);
         $display("vector %0d: keys=%02h note_valid=%0d note=%0d", i, vecs[i].keys,
                  bus.note_valid_o, bus.note_o);
      end
      bus.keys_i = '0;
      @(negedge clk);

      // Free play: silent key 1 wins priority, then key 2 gives a 10-cycle period
      tbl_write(2, 5);
      tbl_write(1, 0);
      bus.keys_i = 8'h06;
      @(negedge clk);
      check("fp_note1", 32'(bus.note_o), 32'd1);
      check("fp_valid1", 32'(bus.note_valid_o), 32'd1);
      pulses = 0;
      repeat (12) begin @(negedge clk); pulses += int'(bus.freq_o); end
      check("fp_silent_highs", 32'(pulses), 32'd0);
      bus.keys_i = 8'h04;
      @(negedge clk);
      check("fp_note2", 32'(bus.note_o), 32'd2);
      check("fp_freq_m0", 32'(bus.freq_o), 32'd0);
      for (int m = 1; m <= 30; m++) begin
         @(negedge clk);
         check($sformatf("fp_freq_m%0d", m), 32'(bus.freq_o), 32'(((m / 5) % 2)));
      end
      bus.keys_i = '0;
      @(negedge clk);
      $display("free play tone sequence done");

      // Random free play with a random pitch table
      for (int i = 0; i < NK; i++)
         tbl_write(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 9));
      rand_free(500);

      // Autoplay song A; a write during busy must be dropped
      for (int i = 0; i < SL; i++) song_tb[i] = '0;
      song_write(0, 2, 3);
      song_write(1, 1, 5);
      song_write(2, 0, 0);
      auto_check("songA", 1'b1);
      auto_check("songA_replay", 1'b0);

      // Lesson
      song_write(0, 1, 4);
      song_write(1, 1, 6);
      song_write(2, 0, 0);
      bus.mode_i = 2'b01; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (3) @(negedge clk);
      check("lsn_led4", 32'(bus.led_o), 32'h10);
      check("lsn_busy", 32'(bus.busy_o), 32'd1);
      bus.keys_i = 8'h04;
      repeat (2) @(negedge clk);
      bus.keys_i = 8'h00;
      repeat (2) @(negedge clk);
      check("lsn_miss1", 32'(bus.miss_cnt_o), 32'd1);
      check("lsn_led4b", 32'(bus.led_o), 32'h10);
      bus.keys_i = 8'h10;
      repeat (4) @(negedge clk);
      check("lsn_led6", 32'(bus.led_o), 32'h40);
      bus.keys_i = 8'h00;
      repeat (2) @(negedge clk);
      check("lsn_miss_hold", 32'(bus.miss_cnt_o), 32'd1);
      bus.keys_i = 8'h40;
      seen = 0;
      for (int c = 0; c < 10 && seen == 0; c++) begin
         @(negedge clk);
         if (bus.done_o) seen = 1;
      end
      check("lsn_done", 32'(seen), 32'd1);
      @(negedge clk);
      check("lsn_idle", 32'(bus.busy_o), 32'd0);
      bus.keys_i = 8'h00;
      @(negedge clk);
      $display("lesson sequence done: miss_cnt=%0d", bus.miss_cnt_o);

      // Lesson miss counter saturation
      bus.mode_i = 2'b01; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (3) @(negedge clk);
      mexp = 0;
      for (int i = 0; i < 260; i++) begin
         bus.keys_i = 8'h01; @(negedge clk);
         bus.keys_i = 8'h00; @(negedge clk);
         if (mexp < 255) mexp++;
      end
      check("lsn_miss_sat", 32'(bus.miss_cnt_o), 32'(mexp));
      bus.mode_i = 2'b00;
      repeat (2) @(negedge clk);
      $display("lesson saturation done: miss_cnt=%0d", bus.miss_cnt_o);

      // Mode change mid-PLAY aborts without done
      song_write(0, 8, 1);
      song_write(1, 0, 0);
      bus.mode_i = 2'b10; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (8) @(negedge clk);
      check("abt_playing", 32'(bus.note_valid_o), 32'd1);
      bus.mode_i = 2'b00;
      @(negedge clk);
      check("abt_busy", 32'(bus.busy_o), 32'd0);
      pulses = 0;
      repeat (40) begin @(negedge clk); pulses += int'(bus.done_o); end
      check("abt_no_done", 32'(pulses), 32'd0);
      $display("abort sequence done");

      // Full song memory, no wrap after the last entry
      for (int i = 0; i < SL; i++) song_write(i, 1, $urandom_range(0, 7));
      auto_check("full", 1'b0);

      // Reset mid-note silences at once and clears the pitch table
      tbl_write(2, 3);
      bus.mode_i = 2'b00;
      bus.keys_i = 8'h04;
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         @(negedge clk);
         if (bus.freq_o) seen = 1;
      end
      check("rmid_sounding", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rmid_freq", 32'(bus.freq_o), 32'd0);
      check("rmid_valid", 32'(bus.note_valid_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (15) begin @(negedge clk); pulses += int'(bus.freq_o); end
      check("rmid_tbl_cleared", 32'(pulses), 32'd0);
      check("rmid_valid_after", 32'(bus.note_valid_o), 32'd1);
      $display("reset mid-note sequence done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/piano_voice_engine.md
# piano_voice_engine

Parametrised tone and sequencing engine for the FPGA piano, generalising the fixed eight-key top level. It has N keys, a run-time programmable pitch table and a loadable song memory. One FSM serves free play, lesson (wait-for-correct-key) and autoplay for any loaded song. It sits between the debounced switch bank and the speaker pin, and feeds the LED bank and seven-segment decoder.

## Interface
- NUM_KEYS, 8: number of keys/pitches; KW = $clog2(NUM_KEYS)
- DIV_W, 18: half-period counter width
- SONG_LEN, 32: song memory depth; AW = $clog2(SONG_LEN)
- BEAT_DIV, 12500000: CLK cycles per quarter beat
- CLK in 1: system clock
- RESET in 1: asynchronous, active-low reset
- keys in NUM_KEYS: debounced key levels
- mode in 2: 00 free, 01 lesson, 10 autoplay, 11 treated as free
- start in 1: one-cycle pulse, starts or restarts lesson/autoplay
- tbl_we in 1, tbl_idx in KW, tbl_data in DIV_W: pitch table write; half-period in cycles, 0 = silent
- song_we in 1, song_addr in AW, song_wdata in KW+4: song entry {dur[3:0], key[KW-1:0]}; dur in quarter beats, dur 0 = end marker
- FREQ out 1: square-wave speaker drive
- note_valid out 1, note out KW: currently sounding key
- Led out NUM_KEYS: one-hot expected key (lesson) or playing key (autoplay), else 0
- busy out 1: FSM not IDLE
- done out 1: one-cycle pulse at song end
- miss_cnt out 8: lesson wrong-key presses, saturating at 255

## Operation
- Key select: lowest-index asserted bit of keys wins; none asserted means no key.
- Sound source:
  - autoplay: the sequencer note.
  - free and lesson: the key select.
  - note_valid=0 means FREQ is held 0.
- Tone generator:
  - Counter cnt counts 0..tbl[note]-1. At terminal count, cnt goes to 0 and FREQ toggles.
  - A change of note or note_valid clears cnt and FREQ on the next edge.
  - tbl entry 0 holds FREQ at 0.
- FSM states: IDLE, FETCH, DECODE, PLAY, GAP, WAIT_KEY, DONE.
  - IDLE: waits for start with mode 01 or 10. On start, addr goes to 0, then FETCH.
  - FETCH: song memory read issued at addr (registered read, 1 cycle).
  - DECODE: entry is valid.
    - dur==0 goes to DONE.
    - Otherwise mode 10 goes to PLAY with the beat counter cleared and a duration counter loaded with dur.
    - Otherwise mode 01 goes to WAIT_KEY.
  - PLAY: each BEAT_DIV cycles decrements the duration counter. At 0, goes to GAP (macro on) or advances.
  - WAIT_KEY:
    - A press that selects the expected key, where the previous cycle did not, advances.
    - A press selecting another key, where the previous cycle had no key, increments miss_cnt.
  - Advance: if addr==SONG_LEN-1, go to DONE (no wrap). Otherwise addr+1, then FETCH.
  - DONE: done=1 for one cycle, then IDLE.
- start while busy restarts from addr 0; miss_cnt clears on every accepted start.
- A mode change while busy aborts to IDLE in the next cycle with no done pulse.
- song_we is ignored while busy. tbl_we is always accepted and takes effect at the next terminal count or note change.

## Timing
- Reset values:
  - FREQ=0, note_valid=0, note=0, Led=0, busy=0, done=0, miss_cnt=0.
  - All pitch table entries 0; FSM in IDLE; addr 0.
- Song memory is not reset.
- Reset mid-operation silences the output on assertion.
- Key to note/note_valid latency: 1 cycle. First FREQ rise comes tbl[n] cycles after note updates.
- start to first autoplay note_valid: 3 cycles (IDLE→FETCH→DECODE→PLAY; note registered on PLAY entry).
- Note duration: exactly dur·BEAT_DIV cycles in PLAY.
- Simultaneous start and abort-causing mode change: the mode check wins.

## Configuration
- PIANO_ARTIC_EN defined: in autoplay, GAP holds note_valid=0 for exactly one BEAT_DIV period between notes, so repeated pitches are audible as separate notes.
- PIANO_ARTIC_EN undefined: GAP is never entered, notes are legato, and the next FETCH follows PLAY directly.

## Test plan
- Bench uses NUM_KEYS=8, BEAT_DIV=4.
- Free play: tbl[2]=5, keys=0b0000_0110 → note=1 (priority), tbl[1]=0 so FREQ stays 0. Then keys=0b100 → FREQ period 10 cycles.
- Autoplay, macro off: song {2,3},{1,5},{0,x}, start → note 3 for 8 cycles, then note 5 for 4 cycles, done pulse, busy falls.
- Autoplay, macro on: same song → 4-cycle note_valid=0 gap between notes 3 and 5.
- Lesson: song {1,4},{1,6},{0,x}.
  - Press key 2 → miss_cnt=1.
  - Press key 4 → Led moves 0x10→0x40.
  - Press key 6 → done.
- Boundary:
  - SONG_LEN fully filled with dur=1 → done after entry 31, no wrap.
  - Mode change mid-PLAY → IDLE with no done.
  - RESET low mid-note → FREQ=0 on assertion.
  - A song_we during busy leaves memory unchanged.
